// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception controller.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_LOCKUP  = 2'd2
  } state_t;

  localparam logic [3:0] EST_NONE   = 4'b0000;
  localparam logic [3:0] EST_IRQ    = 4'b0001;
  localparam logic [3:0] EST_UNDEF  = 4'b0010;
  localparam logic [3:0] EST_LOCKUP = 4'b1111;

  localparam logic [1:0] MRS_ELR = 2'b00;
  localparam logic [1:0] MRS_ESR = 2'b01;
  localparam logic [1:0] MRS_ERR = 2'b10;
  localparam logic [1:0] MRS_CNT = 2'b11;

endpackage

// File: rtl/exc_sysregs.sv
// ELR/ESR/ERR storage, saturating exception counter and MRS readback mux.
module exc_sysregs
  import exc_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             take,
  input  logic             nest,
  input  logic [3:0]       cause,
  input  logic [N-1:0]     pc,
  input  logic [1:0]       mrs_sel,
  output logic [N-1:0]     elr,
  output logic [N-1:0]     mrs_data,
  output logic [CNT_W-1:0] exc_count
);

  logic [3:0]   esr;
  logic [N-1:0] err;

  always_ff @(posedge clk) begin
    if (reset) begin
      elr       <= '0;
      esr       <= '0;
      err       <= '0;
      exc_count <= '0;
    end else if (take) begin
      esr <= cause;
      err <= pc;
      // IRQs re-execute the squashed instruction; faults skip past it.
      elr <= (cause == EST_IRQ) ? pc : pc + N'(4);
      if (exc_count != '1) exc_count <= exc_count + 1'b1;
    end else if (nest) begin
      esr <= EST_LOCKUP;
      err <= pc;
    end
  end

  always_comb begin
    mrs_data = '0;
    case (mrs_sel)
      MRS_ELR: mrs_data = elr;
      MRS_ESR: mrs_data[3:0] = esr;
      MRS_ERR: mrs_data = err;
      MRS_CNT: mrs_data[CNT_W-1:0] = exc_count;
      default: mrs_data = '0;
    endcase
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: handler-mode FSM, IRQ pending/masking and PC redirect.
//   state      | meaning
//   ST_RUN     | normal execution, IRQs unmasked
//   ST_HANDLER | inside exception handler, IRQs masked, ERET returns to ELR
//   ST_LOCKUP  | fault inside handler, PC frozen until reset
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          N           = 64,
  parameter logic [N-1:0] VECTOR_ADDR = 64'h00000000000000D8,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Exc,
  input  logic             ERet,
  input  logic [3:0]       EStatus,
  input  logic [N-1:0]     pc_i,
  input  logic             irq_req,
  output logic             irq_ack,
  output logic             ExtIRQ,
  output logic             pc_redirect,
  output logic [N-1:0]     pc_target,
  output logic             stall,
  input  logic [1:0]       mrs_sel,
  output logic [N-1:0]     mrs_data,
  output logic             in_handler,
  output logic [CNT_W-1:0] exc_count
);

  state_t       state_q, state_d;
  logic         irq_pending;
  logic         take, nest, redirect_raw;
  logic [N-1:0] elr;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    take         = 1'b0;
    nest         = 1'b0;
    redirect_raw = 1'b0;
    pc_target    = VECTOR_ADDR;
    case (state_q)
      ST_RUN: begin
        if (Exc) begin
          take         = 1'b1;
          redirect_raw = 1'b1;
          state_d      = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (Exc) begin
          nest    = 1'b1;
          state_d = ST_LOCKUP;
        end else if (ERet) begin
          redirect_raw = 1'b1;
          pc_target    = elr;
          state_d      = ST_RUN;
        end
      end
      ST_LOCKUP: state_d = ST_LOCKUP;
      default:   state_d = ST_RUN;
    endcase
  end

  // Outputs are held quiet while reset is asserted, even before the reset edge.
  assign irq_ack     = ~reset & take & (EStatus == EST_IRQ);
  assign ExtIRQ      = ~reset & irq_pending & (state_q == ST_RUN);
  assign pc_redirect = ~reset & redirect_raw;
  assign stall       = ~reset & (state_q == ST_LOCKUP);
  assign in_handler  = (state_q == ST_HANDLER);

  always_ff @(posedge clk) begin
    if (reset)        irq_pending <= 1'b0;
    else if (irq_ack) irq_pending <= 1'b0;
    else if (irq_req) irq_pending <= 1'b1;
  end

  exc_sysregs #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_sysregs (
    .clk       (clk),
    .reset     (reset),
    .take      (take),
    .nest      (nest),
    .cause     (EStatus),
    .pc        (pc_i),
    .mrs_sel   (mrs_sel),
    .elr       (elr),
    .mrs_data  (mrs_data),
    .exc_count (exc_count)
  );

endmodule
